pseudo_sensor_gen: RTL and testbench
====================================

// Module: pseudo_sensor_gen
// PURPOSE
//  Synthetic image-sensor source for the LeNet-5 datapath. Emits IMG_W x IMG_H frames of PIX_W-bit
//  pixels on a valid/ready stream, with SOF/EOL/EOF markers and programmable H/V blanking. Sits
//  directly downstream of the pseudo-sensor reset synchronizer. Feeds the CNN input line buffer.
// PARAMETERS
//  IMG_W   28  pixels per line (>=2)
//  IMG_H   28  lines per frame (>=2)
//  PIX_W   8   pixel width, 1..16
//  HBLANK  4   idle cycles after each line except the last; 0 = none
//  VBLANK  16  idle cycles after each frame; 0 = none
// PORTS
//  clk         in   1      clock
//  arst_n      in   1      reset, asynchronous, active-low
//  enable      in   1      continuous mode; frames repeat while high
//  start       in   1      single-cycle pulse; launches one frame from IDLE
//  pattern_sel in   2      0 ramp, 1 checker, 2 LFSR, 3 constant; sampled at frame start only
//  seed        in   16     LFSR seed / constant value; sampled at frame start only
//  m_valid     out  1      pixel valid
//  m_ready     in   1      downstream accept
//  m_data      out  PIX_W  pixel value
//  m_sof       out  1      first pixel of frame (x=0,y=0)
//  m_eol       out  1      last pixel of line (x=IMG_W-1)
//  m_eof       out  1      last pixel of frame
//  busy        out  1      high in every state except IDLE
//  frame_cnt   out  16     completed frames; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE. x, y, counters and LFSR cleared. Reset mid-frame aborts at once.
//    No partial-frame recovery.
//  FSM: IDLE -> ACTIVE -> (HBLANK -> ACTIVE)* -> VBLANK -> IDLE | ACTIVE.
//  IDLE: start=1 or enable=1 -> ACTIVE next cycle. Latch pattern_sel and seed.
//    Load LFSR with seed; seed 0 is replaced by 16'hACE1. m_valid=1 on the first ACTIVE cycle
//    (1-cycle latency).
//  ACTIVE: outputs registered. m_data/m_sof/m_eol/m_eof stay stable while m_valid && !m_ready.
//    The pixel advances only on a handshake (m_valid && m_ready). m_valid never drops mid-line.
//  Handshake on x=IMG_W-1, y<IMG_H-1:
//    HBLANK>0: m_valid=0 next cycle, go to HBLANK.
//    HBLANK=0: next pixel back-to-back.
//  Handshake on the last pixel: frame_cnt+1 in the same clock edge, then go to VBLANK (HBLANK skipped).
//  HBLANK/VBLANK: m_valid=0. Count exactly N clk cycles, independent of m_ready.
//  End of VBLANK (or immediately if VBLANK=0):
//    enable=1 -> ACTIVE (new frame, re-latch inputs, reseed LFSR).
//    enable=0 -> IDLE.
//  start while busy: ignored. Not queued.
//  enable falling mid-frame: the current frame completes in full. It is never truncated.
//  Patterns, with x,y 0-based:
//    ramp:     (x+y) mod 2^PIX_W.
//    checker:  all-ones if ((x>>2)^(y>>2))&1, else 0.
//    LFSR:     low PIX_W bits of a Fibonacci LFSR, x^16+x^14+x^13+x^11+1. Shifts once per handshake.
//    constant: seed[PIX_W-1:0].
//  Counter widths: x and y use $clog2 of IMG_W and IMG_H. Blanking counter is $clog2(max(HBLANK,VBLANK)+1).
// STRUCTURE
//  pseudo_sensor_pkg holds:
//    FSM state enum (IDLE/ACTIVE/HBLANK/VBLANK)
//    pattern codes PAT_RAMP=0, PAT_CHECK=1, PAT_LFSR=2, PAT_CONST=3
//    LFSR_TAPS=16'hB400, LFSR_DEF_SEED=16'hACE1
//  One sub-module, ps_lfsr16: load, advance, 16-bit state output, shares arst_n and clk.
//  Everything else is in the top module.
// TESTING
//  1 Reset, then start pulse, ramp, m_ready=1, defaults:
//    m_valid rises 1 cycle after start; first data 0x00 with m_sof=1.
//    Line 0 ends at 0x1B with m_eol=1, followed by a 4-cycle gap.
//    Final pixel 0x36 has m_eof=1. frame_cnt=1. Then 16 idle cycles, then IDLE with busy=0.
//  2 Backpressure: random m_ready at 50%, checker pattern.
//    Data stays stable while stalled. Exactly 784 handshakes. Pixel (4,0)=0xFF, pixel (4,4)=0x00.
//  3 LFSR with seed=0: sequence matches a reference model seeded 0xACE1.
//    A second frame with seed=0x1234 restarts from 0x1234.
//  4 Continuous mode: enable held for 3 frames, then dropped mid-frame 3.
//    Frame 3 completes; frame_cnt=3; FSM returns to IDLE. A start pulse mid-frame has no effect.
//  5 Reset mid-line: arst_n low at pixel (10,5). All outputs go to 0 at once, frame_cnt=0.
//    After release, start yields a clean SOF at pixel 0x00.
//  6 Wrap: force frame_cnt to 0xFFFF; after the next EOF it reads 0x0000.

Source files
------------

// File: rtl/pseudo_sensor_pkg.sv
// Shared types and constants for the synthetic image-sensor source.
// Holds the FSM state encoding, pattern codes and LFSR polynomial helpers.
package pseudo_sensor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } ps_state_e;

  typedef enum logic [1:0] {
    PAT_RAMP  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_LFSR  = 2'd2,
    PAT_CONST = 2'd3
  } ps_pat_e;

  // x^16+x^14+x^13+x^11+1 as bit positions 15,13,12,10 of a left-shifting register
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_DEF_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pseudo_sensor_gen_if.sv
// Pixel stream from the pseudo sensor to the CNN line buffer.
// Valid/ready handshake with frame/line markers travelling alongside the data.
interface pseudo_sensor_gen_if #(
  parameter int PIX_W = 8
);
  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_sof;
  logic             m_eol;
  logic             m_eof;

  modport master (output m_valid, m_data, m_sof, m_eol, m_eof, input m_ready);
  modport slave  (input m_valid, m_data, m_sof, m_eol, m_eof, output m_ready);
endinterface

// File: rtl/pseudo_sensor_gen_lfsr.sv
// 16-bit Fibonacci LFSR for the random test pattern.
// Load wins over advance; a zero seed would lock up, so it is swapped for the default.
module ps_lfsr16
  import pseudo_sensor_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic        load,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)      state <= '0;
    else if (load)    state <= (seed == '0) ? LFSR_DEF_SEED : seed;
    else if (advance) state <= lfsr_next(state);
  end

endmodule

// File: rtl/pseudo_sensor_gen.sv
// Synthetic image-sensor source: IMG_W x IMG_H frames on a valid/ready stream
// with SOF/EOL/EOF markers, programmable blanking and four test patterns.
module pseudo_sensor_gen
  import pseudo_sensor_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int PIX_W  = 8,
  parameter int HBLANK = 4,
  parameter int VBLANK = 16
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                enable,
  input  logic                start,
  input  logic [1:0]          pattern_sel,
  input  logic [15:0]         seed,
  pseudo_sensor_gen_if.master m,
  output logic                busy,
  output logic [15:0]         frame_cnt
);

  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BW   = (BMAX > 0) ? $clog2(BMAX + 1) : 1;

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [BW-1:0] HB_LOAD = BW'((HBLANK > 0) ? HBLANK - 1 : 0);
  localparam logic [BW-1:0] VB_LOAD = BW'((VBLANK > 0) ? VBLANK - 1 : 0);

  ps_state_e        state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  ps_pat_e          pat_q;
  logic [PIX_W-1:0] cval_q;
  logic [15:0]      frame_cnt_q;
  logic [15:0]      lfsr_state;

  logic frame_go, hs, line_end, frame_end, valid;

  assign valid     = (state_q == ST_ACTIVE);
  assign hs        = valid && m.m_ready;
  assign line_end  = (x_q == X_LAST);
  assign frame_end = line_end && (y_q == Y_LAST);

  // frame_go marks every frame launch: it resets x/y, latches the pattern and reseeds
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    bcnt_d   = bcnt_q;
    frame_go = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start || enable) frame_go = 1'b1;
      end
      ST_ACTIVE: begin
        if (hs) begin
          if (!line_end) begin
            x_d = x_q + XW'(1);
          end else if (!frame_end) begin
            x_d = '0;
            y_d = y_q + YW'(1);
            if (HBLANK > 0) begin
              state_d = ST_HBLANK;
              bcnt_d  = HB_LOAD;
            end
          end else begin
            x_d = '0;
            y_d = '0;
            if (VBLANK > 0) begin
              state_d = ST_VBLANK;
              bcnt_d  = VB_LOAD;
            end else if (enable) begin
              frame_go = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_HBLANK: begin
        if (bcnt_q == '0) state_d = ST_ACTIVE;
        else              bcnt_d  = bcnt_q - BW'(1);
      end
      ST_VBLANK: begin
        if (bcnt_q == '0) begin
          if (enable) frame_go = 1'b1;
          else        state_d  = ST_IDLE;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (frame_go) begin
      state_d = ST_ACTIVE;
      x_d     = '0;
      y_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      bcnt_q      <= '0;
      pat_q       <= PAT_RAMP;
      cval_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bcnt_q  <= bcnt_d;
      if (frame_go) begin
        pat_q  <= ps_pat_e'(pattern_sel);
        cval_q <= seed[PIX_W-1:0];
      end
      if (hs && frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  ps_lfsr16 u_lfsr (
    .clk     (clk),
    .arst_n  (arst_n),
    .load    (frame_go),
    .advance (hs),
    .seed    (seed),
    .state   (lfsr_state)
  );

  // Checker tiles are 4x4: bit 2 of each coordinate selects the tile parity
  logic             chk_bit;
  logic [PIX_W-1:0] pix;
  logic             lfsr_unused;

  assign chk_bit     = (|(x_q & XW'(4))) ^ (|(y_q & YW'(4)));
  assign lfsr_unused = ^(lfsr_state >> PIX_W);

  always_comb begin
    case (pat_q)
      PAT_RAMP:  pix = PIX_W'(x_q) + PIX_W'(y_q);
      PAT_CHECK: pix = {PIX_W{chk_bit}};
      PAT_LFSR:  pix = lfsr_state[PIX_W-1:0];
      default:   pix = cval_q;
    endcase
  end

  // All stream outputs are functions of flops only; nothing combinational from m_ready
  assign m.m_valid = valid;
  assign m.m_data  = valid ? pix : '0;
  assign m.m_sof   = valid && (x_q == '0) && (y_q == '0);
  assign m.m_eol   = valid && line_end;
  assign m.m_eof   = valid && frame_end;
  assign busy      = (state_q != ST_IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pseudo_sensor_gen.sv
// Scoreboard bench for pseudo_sensor_gen: stimulus pushes expected beats,
// a negedge monitor pops and compares them and checks blanking, stalls and frame count.
module tb_pseudo_sensor_gen;
  localparam int W = 28, H = 28, HB = 4, VB = 16, NPIX = W * H;

  logic        clk = 1'b0, arst_n = 1'b0, enable = 1'b0, start = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] seed = 16'd0;
  logic        busy;
  logic [15:0] frame_cnt;

  pseudo_sensor_gen_if #(.PIX_W(8)) ifc();

  pseudo_sensor_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .HBLANK(HB), .VBLANK(VB)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .start(start),
    .pattern_sel(pattern_sel), .seed(seed), .m(ifc), .busy(busy), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic sof, eol, eof; } beat_t;
  beat_t      exp_q[$];
  logic [7:0] hist[$];
  int         nvec = 0, nerr = 0;
  bit         rnd_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame from the pattern definitions, 0-based x/y, LFSR shifting once per pixel
  task automatic push_frame(input int pat, input logic [15:0] sd);
    logic [15:0] s;
    beat_t       b;
    s = (sd == 16'd0) ? 16'hACE1 : sd;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        case (pat)
          0:       b.d = 8'((x + y) % 256);
          1:       b.d = ((((x >> 2) ^ (y >> 2)) & 1) != 0) ? 8'hFF : 8'h00;
          2:       b.d = s[7:0];
          default: b.d = sd[7:0];
        endcase
        b.sof = (x == 0 && y == 0);
        b.eol = (x == W - 1);
        b.eof = (x == W - 1 && y == H - 1);
        exp_q.push_back(b);
        s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      end
  endtask

  // Monitor
  int          gap = 0;
  logic        last_eol = 1'b0, last_eof = 1'b0, stall = 1'b0, fc_pend = 1'b0;
  beat_t       held;
  logic [15:0] fc_exp;

  always @(negedge clk) begin
    beat_t act, e;
    if (!arst_n) begin
      gap = 0; last_eol = 1'b0; last_eof = 1'b0; stall = 1'b0; fc_pend = 1'b0;
    end else begin
      act = {ifc.m_data, ifc.m_sof, ifc.m_eol, ifc.m_eof};
      if (fc_pend) begin
        chk("frame_cnt_inc", 32'(frame_cnt), 32'(fc_exp));
        fc_pend = 1'b0;
      end
      if (stall) chk("stall_hold", 32'({ifc.m_valid, act}), 32'({1'b1, held}));
      stall = ifc.m_valid && !ifc.m_ready;
      held  = act;
      if (ifc.m_valid) begin
        if (last_eol && !last_eof) chk("hblank_gap", 32'(gap), 32'(HB));
        if (last_eof)              chk("vblank_gap", 32'(gap), 32'(VB));
        last_eol = 1'b0; last_eof = 1'b0; gap = 0;
        if (ifc.m_ready) begin
          hist.push_back(ifc.m_data);
          if (exp_q.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_beat: got %h, expected none (t=%0t)", act, $time);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 32'(act), 32'(e));
          end
          last_eol = ifc.m_eol;
          last_eof = ifc.m_eof;
          if (ifc.m_eof) begin
            fc_pend = 1'b1;
            fc_exp  = frame_cnt + 16'd1;
          end
        end
      end else if (busy) begin
        gap++;
      end else begin
        if (last_eof) chk("vblank_idle_gap", 32'(gap), 32'(VB));
        last_eol = 1'b0; last_eof = 1'b0; gap = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    repeat (2) tick();
    arst_n = 1'b1;
    tick();
    exp_q.delete();
    hist.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 6000) begin tick(); k++; end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic wait_hs(input int n);
    int k = 0;
    while (hist.size() < n && k < 6000) begin tick(); k++; end
    chk("hs_reached", 32'(hist.size() >= n), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    ifc.m_ready = 1'b1;

    // 1: reset state, single ramp frame with free-flowing ready
    do_reset();
    chk("rst_valid", 32'(ifc.m_valid), 32'd0);
    chk("rst_data_flags", 32'({ifc.m_data, ifc.m_sof, ifc.m_eol, ifc.m_eof}), 32'd0);
    chk("rst_busy_cnt", 32'({busy, frame_cnt}), 32'd0);
    pattern_sel = 2'd0; seed = 16'd0;
    push_frame(0, 16'd0);
    start = 1'b1;
    chk("valid_before_start", 32'(ifc.m_valid), 32'd0);
    tick();
    start = 1'b0;
    chk("valid_rise", 32'({ifc.m_valid, ifc.m_sof, busy}), 32'b111);
    wait_idle();
    chk("t1_beats", 32'(hist.size()), NPIX);
    chk("t1_first", 32'(hist[0]), 32'h00);
    chk("t1_eol0", 32'(hist[27]), 32'h1B);
    chk("t1_eof", 32'(hist[783]), 32'h36);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: checker under random backpressure
    do_reset();
    pattern_sel = 2'd1;
    push_frame(1, 16'd0);
    rnd_en = 1'b1;
    fork
      begin
        while (rnd_en) begin
          @(posedge clk); #1;
          ifc.m_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    pulse_start();
    wait_idle();
    rnd_en = 1'b0;
    tick(); tick();
    ifc.m_ready = 1'b1;
    chk("t2_beats", 32'(hist.size()), NPIX);
    chk("t2_pix_4_0", 32'(hist[4]), 32'hFF);
    chk("t2_pix_4_4", 32'(hist[116]), 32'h00);
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: LFSR, zero seed then explicit seed; inputs changed mid-frame must not matter
    do_reset();
    pattern_sel = 2'd2; seed = 16'd0;
    push_frame(2, 16'd0);
    pulse_start();
    pattern_sel = 2'd3; seed = 16'h5555;
    wait_idle();
    chk("t3_lfsr0_p0", 32'(hist[0]), 32'hE1);
    chk("t3_lfsr0_p1", 32'(hist[1]), 32'hC3);
    hist.delete();
    pattern_sel = 2'd2; seed = 16'h1234;
    push_frame(2, 16'h1234);
    pulse_start();
    wait_idle();
    chk("t3_lfsr1_p0", 32'(hist[0]), 32'h34);
    chk("t3_lfsr1_p1", 32'(hist[1]), 32'h69);
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4: continuous mode, pattern switch takes effect at next frame, stray start ignored
    do_reset();
    pattern_sel = 2'd0; seed = 16'd0;
    push_frame(0, 16'd0);
    push_frame(1, 16'd0);
    push_frame(1, 16'd0);
    enable = 1'b1;
    wait_hs(100);
    pattern_sel = 2'd1;
    wait_hs(NPIX + 200);
    pulse_start();
    wait_hs(2 * NPIX + 300);
    enable = 1'b0;
    wait_idle();
    repeat (5) tick();
    chk("t4_stays_idle", 32'(busy), 32'd0);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd3);
    chk("t4_beats", 32'(hist.size()), 3 * NPIX);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: asynchronous reset while pixel (10,5) is presented
    hist.delete();
    pattern_sel = 2'd0;
    push_frame(0, 16'd0);
    pulse_start();
    wait_hs(150);
    ifc.m_ready = 1'b0;
    chk("t5_pre_rst", 32'({ifc.m_valid, ifc.m_data}), 32'h10F);
    #1 arst_n = 1'b0;
    #1;
    chk("t5_rst_stream", 32'({ifc.m_valid, ifc.m_data, ifc.m_sof, ifc.m_eol, ifc.m_eof}), 32'd0);
    chk("t5_rst_busy_cnt", 32'({busy, frame_cnt}), 32'd0);
    exp_q.delete();
    hist.delete();
    tick(); tick();
    arst_n = 1'b1;
    ifc.m_ready = 1'b1;
    tick();
    push_frame(0, 16'd0);
    pulse_start();
    chk("t5_clean_sof", 32'({ifc.m_valid, ifc.m_sof, ifc.m_data}), 32'h300);
    wait_idle();
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd1);

    // 6: frame counter wrap, constant pattern
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    tick();
    chk("t6_forced", 32'(frame_cnt), 32'hFFFF);
    hist.delete();
    pattern_sel = 2'd3; seed = 16'h00A5;
    push_frame(3, 16'h00A5);
    pulse_start();
    wait_idle();
    chk("t6_wrap", 32'(frame_cnt), 32'd0);
    chk("t6_const_pix", 32'(hist[300]), 32'hA5);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
